// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule word type, round constants and byte-rotation helpers.
// Used by the key-expansion engine and the cipher round datapath.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ks_state_e;

  // Index 0 and 11..15 are never selected; padding keeps any 4-bit index in range.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic int nr_of(int nk);
    return nk + 6;
  endfunction

  // {b0,b1,b2,b3} -> {b1,b2,b3,b0}, byte 0 in the MSB.
  function automatic word_t rot_word(word_t x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Control and round-key stream bundle of the key-expansion engine.
// master = the engine side, slave = the controller / round-key consumer side.
interface aes_key_expand_seq_if #(
  parameter int NK = 4
);
  logic              start;
  logic [32*NK-1:0]  key;
  logic              busy;
  logic              done;
  logic              rk_valid;
  logic              rk_ready;
  logic [127:0]      rk_data;
  logic [3:0]        rk_round;

  modport master (
    input  start, key, rk_ready,
    output busy, done, rk_valid, rk_data, rk_round
  );

  modport slave (
    output start, key, rk_ready,
    input  busy, done, rk_valid, rk_data, rk_round
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (8-bit in, 8-bit out), shared by key schedule and cipher rounds.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one key word per cycle from an NK-word sliding window,
// grouped into 128-bit round keys and delivered over a valid/ready stream.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_key_expand_seq_if.master io
);

  localparam int NR     = nr_of(NK);
  localparam int NWORDS = 4 * (NR + 1);
  localparam int IW     = $clog2(NWORDS + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_key_expand_seq: NK must be 4, 6 or 8");
  end

  ks_state_e state, state_nxt;

  word_t          win [NK];      // win[0] = w[i-NK], win[NK-1] = w[i-1]
  word_t          asm_buf [4];
  logic           asm_full;
  logic [IW-1:0]  widx;
  logic [2:0]     col;           // widx mod NK
  logic [3:0]     rc_idx;        // widx div NK

  logic           rk_valid_q;
  logic [127:0]   rk_data_q;
  logic [3:0]     rk_round_q;
  logic           done_q;

  logic  xfer, out_free, last_xfer, gen_en;
  word_t x_word, sb_in, sb_out, f_word, new_word;

  assign xfer      = rk_valid_q && io.rk_ready;
  assign out_free  = !rk_valid_q || io.rk_ready;
  assign last_xfer = xfer && (rk_round_q == 4'(NR));
  assign gen_en    = (state == ST_RUN) && (widx < IW'(NWORDS)) && (!asm_full || out_free);

  assign x_word = win[NK-1];
  assign sb_in  = (col == 3'd0) ? rot_word(x_word) : x_word;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sb_in[8*b +: 8]),
      .y (sb_out[8*b +: 8])
    );
  end

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    f_word = x_word;
    if (col == 3'd0) begin
      f_word = sb_out ^ {RCON[rc_idx], 24'h0};
    end else if (NK == 8 && col == 3'd4) begin
      f_word = sb_out;
    end
    // The first NK words are the key itself; rotating them through the window leaves
    // w[0..NK-1] in place for the first derived word.
    new_word = (widx < IW'(NK)) ? win[0] : (win[0] ^ f_word);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (io.start)  state_nxt = ST_RUN;
      ST_RUN:  if (last_xfer) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the window and assembly buffer are small register arrays, not RAM, so they are
  // cleared by reset like any other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NK; j++) win[j] <= '0;
      for (int j = 0; j < 4; j++)  asm_buf[j] <= '0;
      asm_full   <= 1'b0;
      widx       <= '0;
      col        <= '0;
      rc_idx     <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (io.start) begin
          for (int j = 0; j < NK; j++) win[j] <= io.key[32*(NK-j)-1 -: 32];
          asm_full   <= 1'b0;
          widx       <= '0;
          col        <= '0;
          rc_idx     <= '0;
          rk_valid_q <= 1'b0;
          rk_round_q <= '0;
        end
      end else begin
        if (xfer) begin
          rk_valid_q <= 1'b0;
          if (last_xfer) done_q <= 1'b1;
          else           rk_round_q <= rk_round_q + 4'd1;
        end

        // A parked group leaves as soon as the output frees up; a new word may enter slot 0
        // in the same cycle.
        if (asm_full && out_free) begin
          rk_data_q  <= {asm_buf[0], asm_buf[1], asm_buf[2], asm_buf[3]};
          rk_valid_q <= 1'b1;
          asm_full   <= 1'b0;
        end

        if (gen_en) begin
          for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
          win[NK-1] <= new_word;
          widx      <= widx + 1'b1;
          if (col == 3'(NK - 1)) begin
            col    <= '0;
            rc_idx <= rc_idx + 4'd1;
          end else begin
            col <= col + 3'd1;
          end

          if (widx[1:0] == 2'd3) begin
            if (out_free) begin
              rk_data_q  <= {asm_buf[0], asm_buf[1], asm_buf[2], new_word};
              rk_valid_q <= 1'b1;
            end else begin
              asm_buf[3] <= new_word;
              asm_full   <= 1'b1;
            end
          end else begin
            asm_buf[widx[1:0]] <= new_word;
          end
        end
      end
    end
  end

  assign io.busy     = (state == ST_RUN);
  assign io.done     = done_q;
  assign io.rk_valid = rk_valid_q;
  assign io.rk_data  = rk_data_q;
  assign io.rk_round = rk_round_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: AES-128/192/256 instances checked against a FIPS-197 model
// whose S-box is derived from GF(2^8) inversion, plus known-answer vectors.
module tb_aes_key_expand_seq;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int           sel_nk = 4;
  logic         start_v = 1'b0;
  logic [255:0] key_v = '0;
  logic         ready_v = 1'b1;

  aes_key_expand_seq_if #(.NK(4)) if4 ();
  aes_key_expand_seq_if #(.NK(6)) if6 ();
  aes_key_expand_seq_if #(.NK(8)) if8 ();

  aes_key_expand_seq #(.NK(4)) u_dut4 (.clk(clk), .reset(reset), .io(if4));
  aes_key_expand_seq #(.NK(6)) u_dut6 (.clk(clk), .reset(reset), .io(if6));
  aes_key_expand_seq #(.NK(8)) u_dut8 (.clk(clk), .reset(reset), .io(if8));

  assign if4.start    = start_v && (sel_nk == 4);
  assign if6.start    = start_v && (sel_nk == 6);
  assign if8.start    = start_v && (sel_nk == 8);
  assign if4.key      = key_v[255:128];
  assign if6.key      = key_v[255:64];
  assign if8.key      = key_v;
  assign if4.rk_ready = ready_v || (sel_nk != 4);
  assign if6.rk_ready = ready_v || (sel_nk != 6);
  assign if8.rk_ready = ready_v || (sel_nk != 8);

  // View of whichever instance is under test.
  logic s_valid, s_ready, s_busy, s_done;
  logic [127:0] s_data;
  logic [3:0]   s_round;
  always_comb begin
    s_valid = if4.rk_valid; s_ready = if4.rk_ready; s_busy = if4.busy;
    s_done  = if4.done;     s_data  = if4.rk_data;  s_round = if4.rk_round;
    if (sel_nk == 6) begin
      s_valid = if6.rk_valid; s_ready = if6.rk_ready; s_busy = if6.busy;
      s_done  = if6.done;     s_data  = if6.rk_data;  s_round = if6.rk_round;
    end else if (sel_nk == 8) begin
      s_valid = if8.rk_valid; s_ready = if8.rk_ready; s_busy = if8.busy;
      s_done  = if8.done;     s_data  = if8.rk_data;  s_round = if8.rk_round;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Transfer log and hold-while-stalled tracking, sampled on the falling edge.
  logic [131:0] rec_q [$];
  int           stab_viol = 0;
  logic         prev_stall = 1'b0;
  logic [131:0] prev_out = '0;
  always @(negedge clk) begin
    if (s_valid && s_ready) rec_q.push_back({s_round, s_data});
    if (prev_stall && (!s_valid || {s_round, s_data} != prev_out)) stab_viol = stab_viol + 1;
    prev_stall = s_valid && !s_ready;
    prev_out   = {s_round, s_data};
  end

  // ---------------- reference model ----------------
  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk [15];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] t);
    return {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus ----------------
  task automatic run_expansion(input int nk, input logic [255:0] key, input int stall_pct,
                               input bit poke, output int cycles, output bit timed_out,
                               output logic busy_seen, output int first_valid);
    int n = 0;
    sel_nk = nk;
    rec_q.delete();
    stab_viol = 0;
    timed_out = 1'b0;
    first_valid = -1;
    @(posedge clk); #1;
    key_v   = key;
    start_v = 1'b1;
    ready_v = ($urandom_range(99) >= stall_pct);
    @(posedge clk); #1;
    busy_seen = s_busy;
    start_v   = 1'b0;
    key_v     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (s_valid && first_valid < 0) first_valid = n;
      if (s_done) break;
      if (n >= 2000) begin timed_out = 1'b1; break; end
      ready_v = ($urandom_range(99) >= stall_pct);
      start_v = poke && (n % 7 == 3);
      if (start_v) key_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    start_v = 1'b0;
    ready_v = 1'b1;
    cycles  = n;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [135:0] got [3];
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got[0] = {if4.busy, if4.rk_valid, if4.done, if4.rk_round, if4.rk_data, 1'b0, 1'b0, 1'b0, 1'b0};
    got[1] = {if6.busy, if6.rk_valid, if6.done, if6.rk_round, if6.rk_data, 1'b0, 1'b0, 1'b0, 1'b0};
    got[2] = {if8.busy, if8.rk_valid, if8.done, if8.rk_round, if8.rk_data, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got[k] !== '0) begin
        n_bad++;
        $display("FAIL reset_state inst %0d: got %h expected all zero", k, got[k]);
      end
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({if4.busy, if4.rk_valid, if6.busy, if6.rk_valid, if8.busy, if8.rk_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy/valid bits %b expected 000000",
               {if4.busy, if4.rk_valid, if6.busy, if6.rk_valid, if8.busy, if8.rk_valid});
    end
  endtask

  task automatic test_aes128();
    int cyc, fv; bit to; logic bz;
    model_expand(4, KEY128);
    run_expansion(4, KEY128, 0, 1'b0, cyc, to, bz, fv);
    n_cmp++; if (to) begin n_bad++; $display("FAIL aes128_timeout: no done within budget"); end
    n_cmp++; if (cyc != 45) begin n_bad++; $display("FAIL aes128_done_cycle: got %0d expected 45", cyc); end
    n_cmp++; if (bz !== 1'b1) begin n_bad++; $display("FAIL aes128_busy: got %b expected 1", bz); end
    n_cmp++; if (fv != 4) begin n_bad++; $display("FAIL aes128_latency: got %0d expected 4", fv); end
    n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL aes128_busy_at_done: got %b expected 0", s_busy); end
    n_cmp++;
    if (rec_q.size() != 11) begin n_bad++; $display("FAIL aes128_count: got %0d expected 11", rec_q.size()); end
    for (int r = 0; r < rec_q.size() && r < 11; r++) begin
      n_cmp++;
      if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
        n_bad++; $display("FAIL aes128_rk%0d: got %h expected %h", r, rec_q[r], {4'(r), exp_rk[r]});
      end
    end
    if (rec_q.size() == 11) begin
      n_cmp++;
      if (rec_q[1][127:0] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
        n_bad++; $display("FAIL aes128_kat_r1: got %h expected a0fafe1788542cb123a339392a6c7605", rec_q[1][127:0]);
      end
      n_cmp++;
      if (rec_q[10][127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
        n_bad++; $display("FAIL aes128_kat_r10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rec_q[10][127:0]);
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (s_done !== 1'b0) begin n_bad++; $display("FAIL aes128_done_pulse: got %b expected 0", s_done); end
  endtask

  task automatic test_aes192();
    int cyc, fv; bit to; logic bz;
    model_expand(6, KEY192);
    run_expansion(6, KEY192, 0, 1'b0, cyc, to, bz, fv);
    n_cmp++; if (to) begin n_bad++; $display("FAIL aes192_timeout: no done within budget"); end
    n_cmp++; if (cyc != 53) begin n_bad++; $display("FAIL aes192_done_cycle: got %0d expected 53", cyc); end
    n_cmp++;
    if (rec_q.size() != 13) begin n_bad++; $display("FAIL aes192_count: got %0d expected 13", rec_q.size()); end
    for (int r = 0; r < rec_q.size() && r < 13; r++) begin
      n_cmp++;
      if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
        n_bad++; $display("FAIL aes192_rk%0d: got %h expected %h", r, rec_q[r], {4'(r), exp_rk[r]});
      end
    end
    if (rec_q.size() == 13) begin
      n_cmp++;
      if (rec_q[12][127:0] !== 128'he98ba06f448c773c8ecc720401002202) begin
        n_bad++; $display("FAIL aes192_kat_r12: got %h expected e98ba06f448c773c8ecc720401002202", rec_q[12][127:0]);
      end
    end
  endtask

  task automatic test_aes256();
    int cyc, fv; bit to; logic bz;
    model_expand(8, KEY256);
    run_expansion(8, KEY256, 0, 1'b0, cyc, to, bz, fv);
    n_cmp++; if (to) begin n_bad++; $display("FAIL aes256_timeout: no done within budget"); end
    n_cmp++; if (cyc != 61) begin n_bad++; $display("FAIL aes256_done_cycle: got %0d expected 61", cyc); end
    n_cmp++;
    if (rec_q.size() != 15) begin n_bad++; $display("FAIL aes256_count: got %0d expected 15", rec_q.size()); end
    for (int r = 0; r < rec_q.size() && r < 15; r++) begin
      n_cmp++;
      if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
        n_bad++; $display("FAIL aes256_rk%0d: got %h expected %h", r, rec_q[r], {4'(r), exp_rk[r]});
      end
    end
    if (rec_q.size() == 15) begin
      n_cmp++;
      if (rec_q[0][127:0] !== KEY256[255:128]) begin
        n_bad++; $display("FAIL aes256_kat_r0: got %h expected %h", rec_q[0][127:0], KEY256[255:128]);
      end
      n_cmp++;
      if (rec_q[14][127:0] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
        n_bad++; $display("FAIL aes256_kat_r14: got %h expected fe4890d1e6188d0b046df344706c631e", rec_q[14][127:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, fv; bit to; logic bz;
    model_expand(4, KEY128);
    run_expansion(4, KEY128, 30, 1'b0, cyc, to, bz, fv);
    n_cmp++; if (to) begin n_bad++; $display("FAIL bp_timeout: no done within budget"); end
    n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL bp_stability: %0d changes while stalled, expected 0", stab_viol); end
    n_cmp++;
    if (rec_q.size() != 11) begin n_bad++; $display("FAIL bp_count: got %0d expected 11", rec_q.size()); end
    for (int r = 0; r < rec_q.size() && r < 11; r++) begin
      n_cmp++;
      if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
        n_bad++; $display("FAIL bp_rk%0d: got %h expected %h", r, rec_q[r], {4'(r), exp_rk[r]});
      end
    end
  endtask

  task automatic test_reset_abort();
    int cyc, fv, n; bit to; logic bz; bit seen;
    model_expand(4, KEY128);
    sel_nk  = 4;
    ready_v = 1'b1;
    @(posedge clk); #1;
    key_v = KEY128; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    n = 0;
    while (!(s_valid && s_round == 4'd5) && n < 200) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n >= 200) begin n_bad++; $display("FAIL abort_reach_r5: round 5 not seen within budget"); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({s_valid, s_busy, s_round} !== 6'b0) begin
      n_bad++; $display("FAIL abort_state: valid/busy/round %b expected 000000", {s_valid, s_busy, s_round});
    end
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (s_valid || s_busy) seen = 1'b1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL abort_quiet: got activity=1 expected 0"); end
    run_expansion(4, KEY128, 0, 1'b0, cyc, to, bz, fv);
    n_cmp++; if (to) begin n_bad++; $display("FAIL abort_restart_timeout: no done within budget"); end
    n_cmp++;
    if (rec_q.size() != 11) begin n_bad++; $display("FAIL abort_restart_count: got %0d expected 11", rec_q.size()); end
    for (int r = 0; r < rec_q.size() && r < 11; r++) begin
      n_cmp++;
      if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
        n_bad++; $display("FAIL abort_restart_rk%0d: got %h expected %h", r, rec_q[r], {4'(r), exp_rk[r]});
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, fv; bit to; logic bz;
    model_expand(4, KEY128);
    run_expansion(4, KEY128, 20, 1'b1, cyc, to, bz, fv);
    n_cmp++; if (to) begin n_bad++; $display("FAIL poke_timeout: no done within budget"); end
    n_cmp++;
    if (rec_q.size() != 11) begin n_bad++; $display("FAIL poke_count: got %0d expected 11", rec_q.size()); end
    for (int r = 0; r < rec_q.size() && r < 11; r++) begin
      n_cmp++;
      if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
        n_bad++; $display("FAIL poke_rk%0d: got %h expected %h", r, rec_q[r], {4'(r), exp_rk[r]});
      end
    end
  endtask

  task automatic test_random_keys();
    int cyc, fv, nk; bit to; logic bz;
    logic [255:0] key;
    for (int t = 0; t < 6; t++) begin
      nk  = (t % 3 == 0) ? 4 : (t % 3 == 1) ? 6 : 8;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (nk == 4) key[127:0] = '0;
      if (nk == 6) key[63:0]  = '0;
      model_expand(nk, key);
      run_expansion(nk, key, 25, 1'b0, cyc, to, bz, fv);
      n_cmp++;
      if (to || rec_q.size() != nk + 7) begin
        n_bad++; $display("FAIL rand%0d_count: got %0d transfers (timeout=%0b) expected %0d", t, rec_q.size(), to, nk + 7);
      end
      for (int r = 0; r < rec_q.size() && r < nk + 7; r++) begin
        n_cmp++;
        if (rec_q[r] !== {4'(r), exp_rk[r]}) begin
          n_bad++; $display("FAIL rand%0d_rk%0d: got %h expected %h", t, r, rec_q[r], {4'(r), exp_rk[r]});
        end
      end
      n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL rand%0d_stability: got %0d expected 0", t, stab_viol); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_reset_abort();
    test_start_while_busy();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
